ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Parameterised N-bit ripple-carry adder with carry-in and carry-out, built from a chain of 1-bit full-adder cells.
- Result, carry-out and valid are registered, giving one cycle of latency.
- Used as the basic unsigned/two's-complement adder primitive in the datapath. Default width is 4 bits.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range is 1 or more.

Ports:
- clk_i  input  1  clock; all registers update on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  qualifies a_i, b_i and c_i in this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- c_i  input  1  carry-in to bit 0.
- s_o  output  WIDTH  registered sum, bits [WIDTH-1:0].
- c_o  output  1  registered carry-out from the MSB cell.
- valid_o  output  1  high for one cycle when s_o and c_o hold a new result.

Behaviour:
- Combinational chain:
  - carry[0] = c_i.
  - For each bit k: sum[k] = a_i[k] ^ b_i[k] ^ carry[k].
  - carry[k+1] = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k])).
  - The chain is a true ripple, one full-adder cell per bit. No carry-lookahead.
- Arithmetic: {c_o, s_o} = a_i + b_i + c_i as an unsigned value of WIDTH+1 bits. No truncation other than the natural WIDTH+1 result.
- Registers:
  - On a rising clk_i edge with valid_i=1: s_o <= sum, c_o <= carry[WIDTH], valid_o <= 1.
  - On a rising clk_i edge with valid_i=0: s_o and c_o hold their previous values, valid_o <= 0.
- Latency: exactly 1 cycle from the valid_i sample to valid_o. A new operand set is accepted every cycle; there is no backpressure.
- Reset:
  - rst_n_i=0 immediately forces s_o=0, c_o=0 and valid_o=0, independent of clk_i.
  - This overrides any in-flight result.
  - The first result after reset deassertion requires a valid_i sample on a clock edge at which rst_n_i=1.
- Boundary conditions:
  - All-ones operands with c_i=1 give s_o = all ones and c_o=1.
  - All-zeros operands with c_i=0 give s_o=0 and c_o=0.
  - X/Z on the inputs while valid_i=0 must not disturb the outputs.
- No internal state other than the output registers.

Optional Feature:
- Macro: RIPPLE_CARRY_OVF_EN.
- When defined:
  - Adds output port ovf_o (1 bit), the registered signed overflow flag: carry[WIDTH] ^ carry[WIDTH-1].
  - ovf_o is updated under the same valid_i rule as s_o and c_o.
  - ovf_o is reset to 0.
- When undefined: the ovf_o port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ripple_carry_pkg holds:
  - the constant RC_DEFAULT_WIDTH = 4;
  - a typedef for the WIDTH+1 result {carry, sum}, used by the bench scoreboard.
- One sub-module, full_adder_1b:
  - inputs a_i, b_i, c_i; outputs s_o, c_o; purely combinational.
  - It is instantiated WIDTH times via generate, with carry chained from c_o of cell k to c_i of cell k+1.
- The top level contains only the chain, the output registers and the optional overflow logic.

Test Plan:
- Reset, then valid_i=1 with a_i=0001, b_i=0001, c_i=1 → next cycle s_o=0011, c_o=0, valid_o=1.
- a_i=0111, b_i=0111, c_i=1 → s_o=1111, c_o=0; with RIPPLE_CARRY_OVF_EN, ovf_o=1.
- a_i=1111, b_i=1111, c_i=1 → s_o=1111, c_o=1 (maximum carry ripple); with the macro, ovf_o=0.
- a_i=1000, b_i=1000, c_i=0 → s_o=0000, c_o=1; with the macro, ovf_o=1.
- Hold case: one valid result (0010+0010 → 0100), then valid_i=0 with changing a_i/b_i → s_o stays 0100, c_o stays 0, valid_o drops to 0 after one cycle.
- Reset mid-operation:
  - Assert rst_n_i=0 between clock edges while valid_o=1 → s_o, c_o and valid_o go to 0 immediately, without waiting for a clock edge.
  - Exhaustive sweep of all 512 input combinations at WIDTH=4, checked against a_i+b_i+c_i.

Source files
------------

// File: rtl/ripple_carry_pkg.sv
// ripple_carry_pkg
//   Shared constants and types for the ripple-carry adder slice.
//   RC_DEFAULT_WIDTH : default operand/sum width of ripple_carry_adder.
//   rc_result_t      : {carry, sum} result at the default width, i.e. the
//                      natural WIDTH+1 bit value of a + b + cin.
package ripple_carry_pkg;

    localparam int unsigned RC_DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic                        carry;
        logic [RC_DEFAULT_WIDTH-1:0] sum;
    } rc_result_t;

endpackage : ripple_carry_pkg

// File: rtl/full_adder_1b.sv
// full_adder_1b
//   Single-bit full adder cell; purely combinational.
//   Ports:
//     a_i  : operand bit A
//     b_i  : operand bit B
//     c_i  : carry in
//     s_o  : sum bit
//     c_o  : carry out
module full_adder_1b (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    always_comb begin
        p   = a_i ^ b_i;
        s_o = p ^ c_i;
        c_o = (a_i & b_i) | (c_i & p);
    end

endmodule : full_adder_1b

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder
//   Parameterised WIDTH-bit ripple-carry adder with registered outputs
//   (one cycle latency, a new operand set accepted every cycle).
//   Optional feature macro: RIPPLE_CARRY_OVF_EN adds the registered signed
//   overflow flag ovf_o.
//   Ports:
//     clk_i    : clock, rising edge
//     rst_n_i  : asynchronous active-low reset
//     valid_i  : qualifies a_i, b_i, c_i this cycle
//     a_i      : operand A [WIDTH-1:0]
//     b_i      : operand B [WIDTH-1:0]
//     c_i      : carry in to bit 0
//     s_o      : registered sum [WIDTH-1:0]
//     c_o      : registered carry out of the MSB cell
//     valid_o  : one-cycle pulse when s_o/c_o hold a new result
//     ovf_o    : registered signed overflow (only with RIPPLE_CARRY_OVF_EN)
module ripple_carry_adder
    import ripple_carry_pkg::*;
#(
    parameter int unsigned WIDTH = RC_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             valid_o
`ifdef RIPPLE_CARRY_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c_i;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        full_adder_1b u_fa (
            .a_i (a_i[k]),
            .b_i (b_i[k]),
            .c_i (carry[k]),
            .s_o (sum[k]),
            .c_o (carry[k+1])
        );
    end

    // Sum and carry only load on valid_i so idle (possibly undriven) inputs
    // never reach the outputs; valid_o follows valid_i unconditionally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_o     <= '0;
            c_o     <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                s_o <= sum;
                c_o <= carry[WIDTH];
            end
        end
    end

`ifdef RIPPLE_CARRY_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 the carry into the MSB is c_i itself.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_o <= 1'b0;
        end else if (valid_i) begin
            ovf_o <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder
//   Directed-vector bench for ripple_carry_adder at WIDTH=4, with an
//   exhaustive sweep of all operand/carry-in combinations.
//   Optional feature macro: RIPPLE_CARRY_OVF_EN also checks ovf_o.
module tb_ripple_carry_adder;
    import ripple_carry_pkg::*;

    localparam int unsigned W = RC_DEFAULT_WIDTH;

    logic         clk_i;
    logic         rst_n_i;
    logic         valid_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         c_i;
    logic [W-1:0] s_o;
    logic         c_o;
    logic         valid_o;
`ifdef RIPPLE_CARRY_OVF_EN
    logic         ovf_o;
`endif

    int n_vec;
    int n_err;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .s_o     (s_o),
        .c_o     (c_o),
        .valid_o (valid_o)
`ifdef RIPPLE_CARRY_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one operand set between edges, then check just after the edge.
    task automatic run_vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic c, input logic [3:0] es, input logic ec,
                           input logic eovf);
        @(negedge clk_i);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        c_i     = c;
        @(posedge clk_i);
        #1;
        $display("  %s: a=%h b=%h c=%b -> expect s=%h c_o=%b ovf=%b", tag, a, b, c, es, ec, eovf);
        check_eq({tag, ".s"}, 8'(s_o), 8'(es));
        check_eq({tag, ".c"}, 8'(c_o), 8'(ec));
        check_eq({tag, ".v"}, 8'(valid_o), 8'd1);
`ifdef RIPPLE_CARRY_OVF_EN
        check_eq({tag, ".ovf"}, 8'(ovf_o), 8'(eovf));
`endif
    endtask

    initial begin
        rc_result_t exp_r;
        logic [3:0] av;
        logic [3:0] bv;
        logic       cv;
        logic       eovf;

        n_vec   = 0;
        n_err   = 0;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        c_i     = 1'b0;

        #1;
        check_eq("rst.s", 8'(s_o), 8'd0);
        check_eq("rst.c", 8'(c_o), 8'd0);
        check_eq("rst.v", 8'(valid_o), 8'd0);

        // Edge while in reset with valid_i high must not produce a result.
        valid_i = 1'b1;
        a_i     = 4'hF;
        b_i     = 4'hF;
        c_i     = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("rst_edge.v", 8'(valid_o), 8'd0);
        check_eq("rst_edge.s", 8'(s_o), 8'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_n_i = 1'b1;

        run_vec("v1",   4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b0);
        run_vec("v2",   4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1);
        run_vec("vmax", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        run_vec("v4",   4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        run_vec("vzero",4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Hold: valid result, then idle with changing and unknown operands.
        run_vec("hold0", 4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i     = 4'b1111;
        b_i     = 4'b0101;
        c_i     = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("hold1.s", 8'(s_o), 8'b0100);
        check_eq("hold1.c", 8'(c_o), 8'd0);
        check_eq("hold1.v", 8'(valid_o), 8'd0);
        @(negedge clk_i);
        a_i = 'x;
        b_i = 'x;
        c_i = 1'bx;
        @(posedge clk_i);
        #1;
        check_eq("hold2.s", 8'(s_o), 8'b0100);
        check_eq("hold2.c", 8'(c_o), 8'd0);
        check_eq("hold2.v", 8'(valid_o), 8'd0);

        // Asynchronous reset between edges while a result is presented.
        run_vec("prerst", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("arst.s", 8'(s_o), 8'd0);
        check_eq("arst.c", 8'(c_o), 8'd0);
        check_eq("arst.v", 8'(valid_o), 8'd0);
`ifdef RIPPLE_CARRY_OVF_EN
        check_eq("arst.ovf", 8'(ovf_o), 8'd0);
`endif
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("postrst.v", 8'(valid_o), 8'd0);
        check_eq("postrst.s", 8'(s_o), 8'd0);

        // Exhaustive sweep, back-to-back valid operands.
        for (int unsigned ai = 0; ai < 16; ai++) begin
            for (int unsigned bi = 0; bi < 16; bi++) begin
                for (int unsigned ci = 0; ci < 2; ci++) begin
                    av = 4'(ai);
                    bv = 4'(bi);
                    cv = 1'(ci);
                    exp_r = rc_result_t'(5'(ai + bi + ci));
                    eovf  = (av[3] == bv[3]) && (exp_r.sum[3] != av[3]);
                    @(negedge clk_i);
                    valid_i = 1'b1;
                    a_i     = av;
                    b_i     = bv;
                    c_i     = cv;
                    @(posedge clk_i);
                    #1;
                    check_eq("sweep.s", 8'(s_o), 8'(exp_r.sum));
                    check_eq("sweep.c", 8'(c_o), 8'(exp_r.carry));
                    check_eq("sweep.v", 8'(valid_o), 8'd1);
`ifdef RIPPLE_CARRY_OVF_EN
                    check_eq("sweep.ovf", 8'(ovf_o), 8'(eovf));
`else
                    if (eovf === 1'bx) check_eq("sweep.ovfmodel", 8'(eovf), 8'd0);
`endif
                end
            end
        end

        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_eq("tail.v", 8'(valid_o), 8'd0);
        check_eq("tail.s", 8'(s_o), 8'hF);
        check_eq("tail.c", 8'(c_o), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ripple_carry_adder
